// File: rtl/ofs_plat_prim_rand_addr_gen.sv
// rtl/ofs_plat_prim_rand_addr_gen.sv - randomized request address burst generator driven by an external LFSR
module ofs_plat_prim_rand_addr_gen #(
    parameter int ADDR_WIDTH  = 48,
    parameter int OFFSET_BITS = 12,
    parameter int ALIGN_BITS  = 6,
    parameter int GAP_BITS    = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_req,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  gap_en,
    input  logic [31:0]           lfsr_value,
    output logic                  lfsr_en,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_last,
    output logic [CNT_WIDTH-1:0]  req_count,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_req_q, num_req_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  gap_en_q, gap_en_d;
    logic [GAP_BITS-1:0]   gap_cnt_q, gap_cnt_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_last_q, req_last_d;
    logic [CNT_WIDTH-1:0]  req_count_q, req_count_d;
    logic                  req_valid_q, req_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  draw;
    logic                  sample_gap;
    logic [ADDR_WIDTH-1:0] draw_base;
    logic [ADDR_WIDTH-1:0] offset;
    logic [GAP_BITS-1:0]   gap_sel;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic [CNT_WIDTH-1:0]  num_req_m1;

    // Only the offset and gap fields of the LFSR word are consumed.
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_value;

    always_comb begin
        state_d     = state_q;
        num_req_d   = num_req_q;
        base_d      = base_q;
        gap_en_d    = gap_en_q;
        gap_cnt_d   = gap_cnt_q;
        req_addr_d  = req_addr_q;
        req_last_d  = req_last_q;
        req_count_d = req_count_q;
        draw        = 1'b0;
        sample_gap  = 1'b0;
        draw_base   = base_q;
        offset      = '0;
        offset[OFFSET_BITS-1:ALIGN_BITS] = lfsr_value[OFFSET_BITS-1:ALIGN_BITS];
        gap_sel     = lfsr_value[31 -: GAP_BITS];
        count_inc   = req_count_q + CNT_WIDTH'(1);
        num_req_m1  = num_req_q - CNT_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    req_count_d = '0;
                    num_req_d   = num_req;
                    base_d      = base_addr;
                    gap_en_d    = gap_en;
                    if (num_req != '0) begin
                        draw       = 1'b1;
                        draw_base  = base_addr;
                        req_last_d = (num_req == CNT_WIDTH'(1));
                        state_d    = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (req_ready) begin
                    req_count_d = count_inc;
                    if (req_last_q) begin
                        state_d = DONE;
                    end else if (gap_en_q && gap_sel != '0) begin
                        sample_gap = 1'b1;
                        gap_cnt_d  = gap_sel;
                        state_d    = GAP;
                    end else begin
                        draw       = 1'b1;
                        req_last_d = (count_inc == num_req_m1);
                    end
                end
            end
            GAP: begin
                // The address for the next request is drawn in the final idle cycle.
                if (gap_cnt_q == GAP_BITS'(1)) begin
                    draw       = 1'b1;
                    req_last_d = (req_count_q == num_req_m1);
                    state_d    = REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (draw) begin
            req_addr_d = draw_base + offset;
        end

        lfsr_en     = reset_n && (draw || sample_gap);
        req_valid_d = (state_d == REQ);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            num_req_q   <= '0;
            base_q      <= '0;
            gap_en_q    <= 1'b0;
            gap_cnt_q   <= '0;
            req_addr_q  <= '0;
            req_last_q  <= 1'b0;
            req_count_q <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_req_q   <= num_req_d;
            base_q      <= base_d;
            gap_en_q    <= gap_en_d;
            gap_cnt_q   <= gap_cnt_d;
            req_addr_q  <= req_addr_d;
            req_last_q  <= req_last_d;
            req_count_q <= req_count_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_last  = req_last_q;
    assign req_count = req_count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
